// File: rtl/hamming_encoder_stream_if.sv
// Stream bundle for the Hamming [7,4] encoder.
// master = data source / sink side; slave = encoder side.
interface hamming_encoder_stream_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             inj_en;
  logic [2:0]       inj_bit;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_codeword;
  logic             out_injected;
  logic [CNT_W-1:0] word_count;

  modport master (
    output in_valid, in_data, inj_en, inj_bit, out_ready,
    input  in_ready, out_valid, out_codeword, out_injected, word_count
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_bit, out_ready,
    output in_ready, out_valid, out_codeword, out_injected, word_count
  );
endinterface

// File: rtl/hamming_encoder_stream.sv
// Streaming Hamming [7,4] encoder with a 2-entry output buffer and optional
// single-bit error injection for exercising the decoder's correction path.
//
// state | meaning
// EMPTY | no buffered codeword, out_valid=0
// ONE   | head entry valid
// FULL  | head and tail valid, in_ready=0
module hamming_encoder_stream #(
  parameter int CNT_W      = 16,
  parameter int INJ_ENABLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  hamming_encoder_stream_if.slave   bus_if
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       head_q, head_d;
  logic [7:0]       tail_q, tail_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic       push;
  logic       pop;
  logic       flip;
  logic [6:0] enc;
  logic [7:0] new_entry;

  // Entry layout is {codeword[6:0], injected}.
  always_comb begin
    enc = {bus_if.in_data[3], bus_if.in_data[2], bus_if.in_data[1], bus_if.in_data[0],
           bus_if.in_data[0] ^ bus_if.in_data[1] ^ bus_if.in_data[3],
           bus_if.in_data[0] ^ bus_if.in_data[1] ^ bus_if.in_data[2],
           bus_if.in_data[0] ^ bus_if.in_data[2] ^ bus_if.in_data[3]};
    flip = (INJ_ENABLE != 0) && bus_if.inj_en && (bus_if.inj_bit != 3'd7);
    new_entry = {enc ^ (flip ? (7'd1 << bus_if.inj_bit) : 7'd0), flip};
  end

  assign push = bus_if.in_valid && (state_q != FULL);
  assign pop  = bus_if.out_ready && (state_q != EMPTY);

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    word_count_d = push ? word_count_q + CNT_W'(1) : word_count_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      head_q       <= '0;
      tail_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus_if.in_ready     = (state_q != FULL);
  assign bus_if.out_valid    = (state_q != EMPTY);
  assign bus_if.out_codeword = head_q[7:1];
  assign bus_if.out_injected = head_q[0];
  assign bus_if.word_count   = word_count_q;

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// Directed bench for hamming_encoder_stream: encode table, back-pressure,
// streaming order, injection with decode recovery, async reset and counter wrap.
module tb_hamming_encoder_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_encoder_stream_if #(.CNT_W(16)) bus ();
  hamming_encoder_stream_if #(.CNT_W(3))  busw ();

  hamming_encoder_stream #(.CNT_W(16), .INJ_ENABLE(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  hamming_encoder_stream #(.CNT_W(3), .INJ_ENABLE(0)) dutw (
    .clk    (clk),
    .rst    (rst),
    .bus_if (busw.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] data;
    logic       inj_en;
    logic [2:0] inj_bit;
    logic [6:0] exp_cw;
    logic       exp_inj;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    ref_enc = {d[3], d[2], d[1], d[0], d[0]^d[1]^d[3], d[0]^d[1]^d[2], d[0]^d[2]^d[3]};
  endfunction

  function automatic logic [2:0] syn(input logic [6:0] c);
    syn = {c[2]^c[3]^c[4]^c[6], c[1]^c[3]^c[4]^c[5], c[0]^c[3]^c[5]^c[6]};
  endfunction

  // Single-error correction by trying each one-bit error pattern.
  function automatic logic [3:0] ref_dec(input logic [6:0] c);
    logic [6:0] cc;
    logic [6:0] m;
    logic [2:0] s;
    cc = c;
    s  = syn(c);
    if (s != 3'd0) begin
      for (int i = 0; i < 7; i++) begin
        m = 7'd1 << i;
        if (syn(m) == s) cc = c ^ m;
      end
    end
    ref_dec = cc[6:3];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'h0, 1'b0, 3'd0, 7'h00, 1'b0};
    vecs[1] = '{4'hF, 1'b0, 3'd0, 7'h7F, 1'b0};
    vecs[2] = '{4'hB, 1'b0, 3'd0, 7'h5C, 1'b0};
    vecs[3] = '{4'h1, 1'b0, 3'd0, 7'h0F, 1'b0};
    vecs[4] = '{4'h8, 1'b0, 3'd0, 7'h45, 1'b0};
    vecs[5] = '{4'hB, 1'b1, 3'd2, 7'h58, 1'b1};
    vecs[6] = '{4'hB, 1'b1, 3'd7, 7'h5C, 1'b0};
    vecs[7] = '{4'h1, 1'b1, 3'd0, 7'h0E, 1'b1};
    vecs[8] = '{4'h8, 1'b1, 3'd6, 7'h05, 1'b1};
    vecs[9] = '{4'h8, 1'b0, 3'd3, 7'h45, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.inj_en    = 1'b0;
    bus.inj_bit   = 3'd0;
    bus.out_ready = 1'b0;
    busw.in_valid  = 1'b0;
    busw.in_data   = 4'h0;
    busw.inj_en    = 1'b0;
    busw.inj_bit   = 3'd0;
    busw.out_ready = 1'b0;

    do_reset();
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_word_count", 32'(bus.word_count), 32'd0);
    chk("reset_codeword", 32'(bus.out_codeword), 32'h00);

    // Encode table, one word at a time with the sink always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[i].data;
      bus.inj_en   = vecs[i].inj_en;
      bus.inj_bit  = vecs[i].inj_bit;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.inj_en   = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("tbl%0d_cw", i), 32'(bus.out_codeword), 32'(vecs[i].exp_cw));
      chk($sformatf("tbl%0d_inj", i), 32'(bus.out_injected), 32'(vecs[i].exp_inj));
      chk($sformatf("tbl%0d_decode", i), 32'(ref_dec(bus.out_codeword)), 32'(vecs[i].data));
      @(negedge clk);
      chk($sformatf("tbl%0d_drained", i), 32'(bus.out_valid), 32'd0);
    end
    chk("tbl_word_count", 32'(bus.word_count), 32'd10);

    // Back-pressure: two words fill the buffer.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hB;
    @(negedge clk);
    chk("bp_ready_after_1", 32'(bus.in_ready), 32'd1);
    bus.in_data = 4'h1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp_head", 32'(bus.out_codeword), 32'h5C);
    @(negedge clk);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold_cw", 32'(bus.out_codeword), 32'h5C);
    chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_cw", 32'(bus.out_codeword), 32'h0F);
    chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("bp_empty", 32'(bus.out_valid), 32'd0);
    chk("bp_word_count", 32'(bus.word_count), 32'd12);

    // Streaming 0..F at full rate from a fresh reset.
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        chk($sformatf("str%0d_valid", i - 1), 32'(bus.out_valid), 32'd1);
        chk($sformatf("str%0d_cw", i - 1), 32'(bus.out_codeword), 32'(ref_enc(4'(i - 1))));
        chk($sformatf("str%0d_ready", i - 1), 32'(bus.in_ready), 32'd1);
      end
      if (i < 16) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 4'(i);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("str_word_count", 32'(bus.word_count), 32'd16);
    chk("str_drained", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while the buffer is full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hF;
    @(negedge clk);
    bus.in_data = 4'hB;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mr_full", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_word_count", 32'(bus.word_count), 32'd0);
    chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mr_codeword", 32'(bus.out_codeword), 32'h00);
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h8;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mr_first_valid", 32'(bus.out_valid), 32'd1);
    chk("mr_first_cw", 32'(bus.out_codeword), 32'h45);
    chk("mr_first_count", 32'(bus.word_count), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mr_no_stale%0d", k), 32'(bus.out_valid), 32'd0);
    end

    // Narrow counter wrap; injection disabled on this instance.
    busw.out_ready = 1'b1;
    busw.in_valid  = 1'b1;
    busw.in_data   = 4'h5;
    busw.inj_en    = 1'b1;
    busw.inj_bit   = 3'd0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("wrap%0d_count", k), 32'(busw.word_count), 32'(k % 8));
      chk($sformatf("wrap%0d_cw", k), 32'(busw.out_codeword), 32'h2C);
      chk($sformatf("wrap%0d_inj", k), 32'(busw.out_injected), 32'd0);
    end
    busw.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
